// File: rtl/svc_rv_mem_arb.sv
// Single-port memory arbiter for svc_rv: shares one 1-cycle-latency BRAM port between
// instruction fetch and data load/store, capturing the loser of a conflict for replay.
module svc_rv_mem_arb #(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          imem_ren,
  input  logic [AW-1:0] imem_raddr,
  output logic [31:0]   imem_rdata,
  output logic          imem_stall,
  input  logic          dmem_ren,
  input  logic [AW-1:0] dmem_raddr,
  output logic [31:0]   dmem_rdata,
  input  logic          dmem_we,
  input  logic [AW-1:0] dmem_waddr,
  input  logic [31:0]   dmem_wdata,
  input  logic [3:0]    dmem_wstrb,
  output logic          dmem_stall,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [CW-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REPLAY_I = 2'd1,
    REPLAY_D = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_cap_addr;
  logic          r_cap_st;
  logic [31:0]   r_cap_wdata;
  logic [3:0]    r_cap_wstrb;
  logic          r_own_valid;
  logic          r_own_d;
  logic [31:0]   r_hold_i;
  logic [31:0]   r_hold_d;
  logic [CW-1:0] r_cnt;

  logic          w_i_new;
  logic          w_d_new;
  logic [AW-1:0] w_d_addr;
  logic          w_rd_i;
  logic          w_rd_d;
  logic          w_cap_load;
  logic          w_cap_st;
  logic [AW-1:0] w_cap_addr;
  logic [31:0]   w_cap_wdata;
  logic [3:0]    w_cap_wstrb;
  logic          w_conflict;

  // Stalls depend on state only; a stalled port's inputs are not a new request.
  assign imem_stall = (r_state == REPLAY_I);
  assign dmem_stall = (r_state == REPLAY_D);
  assign w_i_new    = imem_ren && !imem_stall;
  assign w_d_new    = (dmem_ren || dmem_we) && !dmem_stall;
  assign w_d_addr   = dmem_we ? dmem_waddr : dmem_raddr;

  assign imem_rdata   = (r_own_valid && !r_own_d) ? mem_rdata : r_hold_i;
  assign dmem_rdata   = (r_own_valid &&  r_own_d) ? mem_rdata : r_hold_d;
  assign conflict_cnt = r_cnt;

  // Issue selection, capture of the losing request, and next state.
  always_comb begin
    w_next      = r_state;
    mem_en      = 1'b0;
    mem_we      = 4'h0;
    mem_addr    = '0;
    mem_wdata   = 32'h0000_0000;
    w_rd_i      = 1'b0;
    w_rd_d      = 1'b0;
    w_cap_load  = 1'b0;
    w_cap_st    = 1'b0;
    w_cap_addr  = '0;
    w_cap_wdata = 32'h0000_0000;
    w_cap_wstrb = 4'h0;
    w_conflict  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_new) begin
          mem_en   = 1'b1;
          mem_addr = w_d_addr;
          if (dmem_we) begin
            mem_we    = dmem_wstrb;
            mem_wdata = dmem_wdata;
          end else begin
            w_rd_d = 1'b1;
          end
          if (w_i_new) begin
            w_cap_load = 1'b1;
            w_cap_addr = imem_raddr;
            w_conflict = 1'b1;
            w_next     = REPLAY_I;
          end else begin
            w_next = IDLE;
          end
        end else if (w_i_new) begin
          mem_en   = 1'b1;
          mem_addr = imem_raddr;
          w_rd_i   = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      REPLAY_I: begin
        mem_en   = 1'b1;
        mem_addr = r_cap_addr;
        w_rd_i   = 1'b1;
        if (w_d_new) begin
          w_cap_load  = 1'b1;
          w_cap_st    = dmem_we;
          w_cap_addr  = w_d_addr;
          w_cap_wdata = dmem_wdata;
          w_cap_wstrb = dmem_wstrb;
          w_conflict  = 1'b1;
          w_next      = REPLAY_D;
        end else begin
          w_next = IDLE;
        end
      end
      REPLAY_D: begin
        mem_en   = 1'b1;
        mem_addr = r_cap_addr;
        if (r_cap_st) begin
          mem_we    = r_cap_wstrb;
          mem_wdata = r_cap_wdata;
        end else begin
          w_rd_d = 1'b1;
        end
        if (w_i_new) begin
          w_cap_load = 1'b1;
          w_cap_addr = imem_raddr;
          w_conflict = 1'b1;
          w_next     = REPLAY_I;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Nothing reaches memory while reset is held, including a pending replay.
    if (reset) begin
      mem_en    = 1'b0;
      mem_we    = 4'h0;
      mem_addr  = '0;
      mem_wdata = 32'h0000_0000;
      w_rd_i    = 1'b0;
      w_rd_d    = 1'b0;
    end else begin
      w_conflict = w_conflict;
    end
  end

  // State, capture, response ownership, rdata holds and conflict counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cap_addr  <= '0;
      r_cap_st    <= 1'b0;
      r_cap_wdata <= 32'h0000_0000;
      r_cap_wstrb <= 4'h0;
      r_own_valid <= 1'b0;
      r_own_d     <= 1'b0;
      r_hold_i    <= 32'h0000_0013;
      r_hold_d    <= 32'h0000_0000;
      r_cnt       <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap_load) begin
        r_cap_addr  <= w_cap_addr;
        r_cap_st    <= w_cap_st;
        r_cap_wdata <= w_cap_wdata;
        r_cap_wstrb <= w_cap_wstrb;
      end
      r_own_valid <= w_rd_i || w_rd_d;
      r_own_d     <= w_rd_d;
      if (r_own_valid && !r_own_d) begin
        r_hold_i <= mem_rdata;
      end
      if (r_own_valid && r_own_d) begin
        r_hold_d <= mem_rdata;
      end
      if (w_conflict && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  a_no_load_and_store: assert property (@(posedge clock) disable iff (reset)
    !(dmem_ren && dmem_we));

endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// Randomized bench for svc_rv_mem_arb: a request-queue model predicts every output each cycle.
module tb_svc_rv_mem_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ren = 1'b0;
  logic [31:0] imem_raddr = 32'h0;
  logic        dmem_ren = 1'b0;
  logic [31:0] dmem_raddr = 32'h0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_waddr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [3:0]  dmem_wstrb = 4'h0;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic        imem_stall, dmem_stall, mem_en;
  logic [3:0]  mem_we;
  logic [15:0] conflict_cnt;

  logic [31:0] imem_rdata2, dmem_rdata2, mem_addr2, mem_wdata2;
  logic        imem_stall2, dmem_stall2, mem_en2;
  logic [3:0]  mem_we2;
  logic [1:0]  conflict_cnt2;

  int n_checks = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  svc_rv_mem_arb u_dut (
    .clock(clock), .reset(reset),
    .imem_ren(imem_ren), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata), .imem_stall(imem_stall),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_stall(dmem_stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  svc_rv_mem_arb #(.AW(32), .CW(2)) u_dut2 (
    .clock(clock), .reset(reset),
    .imem_ren(imem_ren), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata2), .imem_stall(imem_stall2),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata2),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_stall(dmem_stall2), .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt2)
  );

  typedef struct packed {
    logic        is_d;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  // Model state: the one request waiting for replay, who gets data this cycle, held data.
  bit          m_pend_v = 1'b0;
  req_t        m_pend = '0;
  bit          m_ret_i = 1'b0;
  bit          m_ret_d = 1'b0;
  logic [31:0] m_hold_i = 32'h13;
  logic [31:0] m_hold_d = 32'h0;
  int          m_conf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    req_t        q[$];
    req_t        r;
    bit          e_istall, e_dstall, i_new, d_new, e_en;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wdata, e_ir, e_dr;
    int          c16, c2;
    if (reset) begin
      m_pend_v = 1'b0; m_ret_i = 1'b0; m_ret_d = 1'b0;
      m_hold_i = 32'h13; m_hold_d = 32'h0; m_conf = 0;
      return;
    end
    e_istall = m_pend_v && !m_pend.is_d;
    e_dstall = m_pend_v && m_pend.is_d;
    i_new = imem_ren && !e_istall;
    d_new = (dmem_ren || dmem_we) && !e_dstall;
    // Priority: replayed capture first, then data port, then fetch.
    if (m_pend_v) q.push_back(m_pend);
    if (d_new) begin
      r = '0; r.is_d = 1'b1; r.st = dmem_we;
      r.addr = dmem_we ? dmem_waddr : dmem_raddr;
      r.wdata = dmem_wdata; r.wstrb = dmem_wstrb;
      q.push_back(r);
    end
    if (i_new) begin
      r = '0; r.addr = imem_raddr;
      q.push_back(r);
    end
    e_en = q.size() > 0;
    e_we = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    if (e_en) begin
      e_addr = q[0].addr;
      if (q[0].st) begin e_we = q[0].wstrb; e_wdata = q[0].wdata; end
    end
    e_ir = m_ret_i ? mem_rdata : m_hold_i;
    e_dr = m_ret_d ? mem_rdata : m_hold_d;
    c16 = (m_conf > 65535) ? 65535 : m_conf;
    c2  = (m_conf > 3) ? 3 : m_conf;
    chk("imem_stall", {31'h0, imem_stall}, {31'h0, e_istall});
    chk("dmem_stall", {31'h0, dmem_stall}, {31'h0, e_dstall});
    chk("mem_en", {31'h0, mem_en}, {31'h0, e_en});
    chk("mem_we", {28'h0, mem_we}, {28'h0, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("imem_rdata", imem_rdata, e_ir);
    chk("dmem_rdata", dmem_rdata, e_dr);
    chk("conflict_cnt", {16'h0, conflict_cnt}, c16);
    chk("cw2_conflict_cnt", {30'h0, conflict_cnt2}, c2);
    chk("cw2_mem_en", {31'h0, mem_en2}, {31'h0, e_en});
    chk("cw2_mem_addr", mem_addr2, e_addr);
    chk("cw2_mem_we", {28'h0, mem_we2}, {28'h0, e_we});
    chk("cw2_mem_wdata", mem_wdata2, e_wdata);
    chk("cw2_stalls", {30'h0, imem_stall2, dmem_stall2}, {30'h0, e_istall, e_dstall});
    chk("cw2_rdata", imem_rdata2 ^ dmem_rdata2, e_ir ^ e_dr);
    if (m_ret_i) m_hold_i = mem_rdata;
    if (m_ret_d) m_hold_d = mem_rdata;
    m_ret_i = e_en && !q[0].is_d;
    m_ret_d = e_en && q[0].is_d && !q[0].st;
    m_pend_v = q.size() > 1;
    if (q.size() > 1) begin
      m_pend = q[1];
      m_conf++;
    end
  endtask

  // dk: 0 none, 1 load, 2 store. The unused dmem address is driven with junk.
  task automatic cyc(input bit rst, input bit ir, input logic [31:0] ia, input int dk,
                     input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] mrd);
    @(posedge clock);
    #1;
    reset = rst;
    imem_ren = ir; imem_raddr = ia;
    dmem_ren = (dk == 1); dmem_we = (dk == 2);
    dmem_raddr = (dk == 2) ? ~da : da;
    dmem_waddr = (dk == 2) ? da : ~da;
    dmem_wdata = wd; dmem_wstrb = ws; mem_rdata = mrd;
    @(negedge clock);
    model_step();
  endtask

  initial begin
    cyc(1, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    cyc(1, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    cyc(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'hDEAD);
    chk("lit_reset_imem_rdata", imem_rdata, 32'h13);
    chk("lit_reset_mem_en", {31'h0, mem_en}, 32'h0);
    chk("lit_reset_cnt", {16'h0, conflict_cnt}, 32'h0);

    // Lone fetch
    cyc(0, 1, 32'h40, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk("lit_fetch_addr", mem_addr, 32'h40);
    chk("lit_fetch_en", {31'h0, mem_en}, 32'h1);
    cyc(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'hA);
    chk("lit_fetch_data", imem_rdata, 32'hA);
    chk("lit_fetch_nostall", {31'h0, imem_stall}, 32'h0);

    // Fetch and load conflict
    cyc(0, 1, 32'h10, 1, 32'h200, 32'h0, 4'h0, 32'h0);
    chk("lit_conf_load_addr", mem_addr, 32'h200);
    cyc(0, 1, 32'h10, 0, 32'h0, 32'h0, 4'h0, 32'h55);
    chk("lit_conf_istall", {31'h0, imem_stall}, 32'h1);
    chk("lit_conf_replay_addr", mem_addr, 32'h10);
    chk("lit_conf_load_data", dmem_rdata, 32'h55);
    cyc(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h66);
    chk("lit_conf_fetch_data", imem_rdata, 32'h66);
    chk("lit_conf_cnt1", {16'h0, conflict_cnt}, 32'h1);

    // Fetch and store conflict
    cyc(0, 1, 32'h10, 2, 32'h300, 32'h1234, 4'h3, 32'h0);
    chk("lit_store_we", {28'h0, mem_we}, 32'h3);
    chk("lit_store_wdata", mem_wdata, 32'h1234);
    chk("lit_store_addr", mem_addr, 32'h300);
    cyc(0, 1, 32'h10, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    chk("lit_store_replay", mem_addr, 32'h10);
    chk("lit_store_istall", {31'h0, imem_stall}, 32'h1);
    cyc(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0);

    // Chained conflicts
    cyc(0, 1, 32'h20, 1, 32'h400, 32'h0, 4'h0, 32'h0);
    cyc(0, 1, 32'h20, 1, 32'h404, 32'h0, 4'h0, 32'h77);
    chk("lit_chain_addr1", mem_addr, 32'h20);
    chk("lit_chain_ddata1", dmem_rdata, 32'h77);
    cyc(0, 1, 32'h24, 1, 32'h404, 32'h0, 4'h0, 32'h88);
    chk("lit_chain_dstall", {31'h0, dmem_stall}, 32'h1);
    chk("lit_chain_idata1", imem_rdata, 32'h88);
    chk("lit_chain_dhold", dmem_rdata, 32'h77);
    chk("lit_chain_addr2", mem_addr, 32'h404);
    cyc(0, 1, 32'h24, 0, 32'h0, 32'h0, 4'h0, 32'h99);
    chk("lit_chain_ihold", imem_rdata, 32'h88);
    chk("lit_chain_ddata2", dmem_rdata, 32'h99);
    cyc(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'hAA);
    chk("lit_chain_idata2", imem_rdata, 32'hAA);
    chk("lit_chain_cnt", {16'h0, conflict_cnt}, 32'h5);
    chk("lit_sat_cnt2", {30'h0, conflict_cnt2}, 32'h3);

    // Reset while a load is being replayed
    cyc(0, 1, 32'h30, 1, 32'h500, 32'h0, 4'h0, 32'h0);
    cyc(0, 1, 32'h30, 1, 32'h504, 32'h0, 4'h0, 32'h1);
    cyc(1, 0, 32'h0, 1, 32'h504, 32'h0, 4'h0, 32'h2);
    cyc(0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h3);
    chk("lit_rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("lit_rst_stalls", {30'h0, imem_stall, dmem_stall}, 32'h0);
    chk("lit_rst_imem_rdata", imem_rdata, 32'h13);
    chk("lit_rst_cnt", {16'h0, conflict_cnt}, 32'h0);

    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
          {22'h0, 8'($urandom_range(0, 255)), 2'b00}, int'($urandom_range(0, 2)),
          {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom, 4'($urandom_range(0, 15)),
          $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
